mcu_bus_regfile: RTL and testbench
==================================

// Module: mcu_bus_regfile
// PURPOSE
// - Upstream configuration stage of the TH99CHLS core.
// - Decodes the multiplexed microcontroller bus: ABUS carries the high address byte, DBUS carries the low address byte and then the data.
// - Holds the coefficient registers B0..B6, the operand register and the hour/minute preset, and supports read-back.
// - Issues a one-cycle time_load pulse so the clock/display datapath picks up a new hour/minute preset.
// PARAMETERS
// - HOUR_MAX     23  largest legal hour value; larger writes are rejected.
// - MINUTE_MAX   59  largest legal minute value; larger writes are rejected.
// - STATUS_ADDR  10  address of the status register (read / write-1-to-clear).
// PORTS
// - clock        in     1   single system clock, all logic on rising edge.
// - reset        in     1   synchronous, active-low (0 = reset, sampled on rising edge).
// - ABUS         in     8   high address byte.
// - DBUS         inout  8   low address byte during ALE=1; data otherwise. Tri-stated unless reading.
// - CSbar        in     1   chip select, active-low.
// - ALE          in     1   address latch enable, active-high.
// - Rbar         in     1   read strobe, active-low.
// - Wbar         in     1   write strobe, active-low.
// - b0..b6       out    8   coefficient registers, addresses 0..6.
// - operand      out    8   operand register, address 7.
// - hour_set     out    5   hour preset, address 8, range 0..HOUR_MAX.
// - minute_set   out    6   minute preset, address 9, range 0..MINUTE_MAX.
// - time_load    out    1   one-cycle pulse after any accepted hour or minute write.
// - err_flags    out    2   {err_range, err_unmapped}; sticky copy of the status register.
// BEHAVIOUR
// - Reset: all registers, outputs and errors = 0; state = IDLE; DBUS = hi-Z. Reset mid-transfer aborts the transfer and releases DBUS at that edge.
// - Address: addr = {ABUS, DBUS}, 16 bits. Mapped addresses are 0..10; anything else is unmapped.
// - FSM states: IDLE, ADDR, READ, WAIT. Transitions evaluated at each rising edge:
//   - IDLE: CSbar=0 & ALE=1 -> latch addr, go to ADDR.
//   - ADDR, priority order:
//     - CSbar=1 -> IDLE.
//     - ALE=1 -> re-latch addr.
//     - Wbar=0 -> commit write with DBUS sampled this edge, go to WAIT.
//     - Rbar=0 & Wbar=1 -> go to READ.
//     - Otherwise hold.
//   - READ: drive DBUS from the cycle after entry while CSbar=0 & Rbar=0. When CSbar=1 or Rbar=1, release DBUS at that edge and go to IDLE or WAIT respectively.
//   - WAIT: hold until CSbar=1, then IDLE. At most one write per chip-select assertion.
// - Write commit:
//   - Register output updates at the commit edge; value visible the following cycle.
//   - time_load is high for exactly the cycle after an accepted write to address 8 or 9.
//   - hour value > HOUR_MAX or minute value > MINUTE_MAX: register unchanged, err_range set, no time_load.
//   - hour_set/minute_set take the low 5/6 bits of an accepted value.
//   - Unmapped address: no register change, err_unmapped set.
//   - Write to STATUS_ADDR: each 1 bit clears the matching error bit.
// - Read data:
//   - Mapped address: register value, zero-extended to 8 bits.
//   - STATUS_ADDR: {6'b0, err_range, err_unmapped}.
//   - Unmapped address: 8'h00, and err_unmapped is set.
// - Simultaneous set and clear of an error bit in the same cycle: set wins.
// - DBUS output-enable is registered, never combinational from the strobes. Never driven while ALE=1.
// TESTING
// - Write sequence B0..B6 = 13,89,73,59,23,67,1; operand=8'hED; hour=23; minute=33 (ALE cycle, data cycle, CSbar high) -> outputs match exactly; time_load pulses twice, one cycle each.
// - Write hour=24, then minute=60 -> hour_set/minute_set unchanged, err_flags=2'b10, no time_load.
// - Write to addr 16'h0100 -> no register changes, err_flags[0]=1. Write 8'h03 to addr 10 -> err_flags=2'b00.
// - Read addr 1 after writing 89 -> DBUS=89 from the second cycle of Rbar=0; hi-Z the cycle after Rbar rises.
// - Hold Wbar=0 for 3 data cycles with changing DBUS -> only the first value committed; ALE re-asserted in ADDR -> new address used.
// - Assert reset=0 during READ -> DBUS hi-Z and all outputs 0 next cycle; the following transfer works normally.

Source files
------------

// File: rtl/mcu_bus_regfile.sv
// Configuration register file behind a multiplexed 8-bit microcontroller bus.
// Holds coefficients, operand, hour/minute preset and sticky error status.
module mcu_bus_regfile #(
  parameter int unsigned HOUR_MAX    = 23,
  parameter int unsigned MINUTE_MAX  = 59,
  parameter int unsigned STATUS_ADDR = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ABUS,
  inout  wire  [7:0] DBUS,
  input  logic       CSbar,
  input  logic       ALE,
  input  logic       Rbar,
  input  logic       Wbar,
  output logic [7:0] b0,
  output logic [7:0] b1,
  output logic [7:0] b2,
  output logic [7:0] b3,
  output logic [7:0] b4,
  output logic [7:0] b5,
  output logic [7:0] b6,
  output logic [7:0] operand,
  output logic [4:0] hour_set,
  output logic [5:0] minute_set,
  output logic       time_load,
  output logic [1:0] err_flags
);

  localparam logic [7:0]  HOUR_MAX_B   = 8'(HOUR_MAX);
  localparam logic [7:0]  MINUTE_MAX_B = 8'(MINUTE_MAX);
  localparam logic [15:0] STATUS_A     = 16'(STATUS_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_READ = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_addr;
  logic [7:0]  r_coef [0:6];
  logic [7:0]  r_operand;
  logic [4:0]  r_hour;
  logic [5:0]  r_minute;
  logic        r_time_load;
  logic        r_err_range;
  logic        r_err_unmapped;
  logic        r_oe;
  logic [7:0]  r_rdata;

  logic        w_latch;
  logic        w_commit;
  logic        w_rd_start;
  logic        w_oe_next;
  logic [7:0]  w_wdata;
  logic [7:0]  w_rd_mux;
  logic        w_hour_ok;
  logic        w_min_ok;
  logic        w_set_range;
  logic        w_set_unm;
  logic [1:0]  w_clr;

  function automatic logic f_in_range(input logic [7:0] value, input logic [7:0] max);
    return value <= max;
  endfunction

  assign w_wdata   = DBUS;
  assign w_hour_ok = f_in_range(w_wdata, HOUR_MAX_B);
  assign w_min_ok  = f_in_range(w_wdata, MINUTE_MAX_B);

  // Bus protocol state register
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_latch    = 1'b0;
    w_commit   = 1'b0;
    w_rd_start = 1'b0;
    w_oe_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!CSbar && ALE) begin
          w_latch = 1'b1;
          w_next  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (CSbar) begin
          w_next = S_IDLE;
        end else if (ALE) begin
          w_latch = 1'b1;
        end else if (!Wbar) begin
          w_commit = 1'b1;
          w_next   = S_WAIT;
        end else if (!Rbar) begin
          w_rd_start = 1'b1;
          w_oe_next  = 1'b1;
          w_next     = S_READ;
        end
      end
      S_READ: begin
        if (CSbar)     w_next = S_IDLE;
        else if (Rbar) w_next = S_WAIT;
        else           w_oe_next = !ALE;
      end
      S_WAIT: begin
        if (CSbar) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Error set/clear decode; a set always overrides a clear
  always_comb begin
    w_set_range = 1'b0;
    w_set_unm   = 1'b0;
    w_clr       = 2'b00;
    if (w_commit) begin
      if (r_addr == STATUS_A)                  w_clr       = w_wdata[1:0];
      else if (r_addr == 16'd8 && !w_hour_ok)  w_set_range = 1'b1;
      else if (r_addr == 16'd9 && !w_min_ok)   w_set_range = 1'b1;
      else if (r_addr > 16'd9)                 w_set_unm   = 1'b1;
    end
    if (w_rd_start && r_addr > 16'd9 && r_addr != STATUS_A) w_set_unm = 1'b1;
  end

  always_comb begin
    w_rd_mux = 8'h00;
    case (r_addr)
      16'd0:   w_rd_mux = r_coef[0];
      16'd1:   w_rd_mux = r_coef[1];
      16'd2:   w_rd_mux = r_coef[2];
      16'd3:   w_rd_mux = r_coef[3];
      16'd4:   w_rd_mux = r_coef[4];
      16'd5:   w_rd_mux = r_coef[5];
      16'd6:   w_rd_mux = r_coef[6];
      16'd7:   w_rd_mux = r_operand;
      16'd8:   w_rd_mux = {3'b000, r_hour};
      16'd9:   w_rd_mux = {2'b00, r_minute};
      default: begin
        if (r_addr == STATUS_A) w_rd_mux = {6'b0, r_err_range, r_err_unmapped};
      end
    endcase
  end

  // Address latch, register commit, read capture and output enable
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_addr         <= 16'h0000;
      for (int i = 0; i < 7; i++) r_coef[i] <= 8'h00;
      r_operand      <= 8'h00;
      r_hour         <= 5'd0;
      r_minute       <= 6'd0;
      r_time_load    <= 1'b0;
      r_err_range    <= 1'b0;
      r_err_unmapped <= 1'b0;
      r_oe           <= 1'b0;
      r_rdata        <= 8'h00;
    end else begin
      r_time_load    <= 1'b0;
      r_oe           <= w_oe_next;
      r_err_range    <= w_set_range | (r_err_range & ~w_clr[1]);
      r_err_unmapped <= w_set_unm | (r_err_unmapped & ~w_clr[0]);
      if (w_latch)    r_addr  <= {ABUS, DBUS};
      if (w_rd_start) r_rdata <= w_rd_mux;
      if (w_commit) begin
        case (r_addr)
          16'd0: r_coef[0] <= w_wdata;
          16'd1: r_coef[1] <= w_wdata;
          16'd2: r_coef[2] <= w_wdata;
          16'd3: r_coef[3] <= w_wdata;
          16'd4: r_coef[4] <= w_wdata;
          16'd5: r_coef[5] <= w_wdata;
          16'd6: r_coef[6] <= w_wdata;
          16'd7: r_operand <= w_wdata;
          16'd8: begin
            if (w_hour_ok) begin
              r_hour      <= w_wdata[4:0];
              r_time_load <= 1'b1;
            end
          end
          16'd9: begin
            if (w_min_ok) begin
              r_minute    <= w_wdata[5:0];
              r_time_load <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign DBUS       = r_oe ? r_rdata : 8'hzz;
  assign b0         = r_coef[0];
  assign b1         = r_coef[1];
  assign b2         = r_coef[2];
  assign b3         = r_coef[3];
  assign b4         = r_coef[4];
  assign b5         = r_coef[5];
  assign b6         = r_coef[6];
  assign operand    = r_operand;
  assign hour_set   = r_hour;
  assign minute_set = r_minute;
  assign time_load  = r_time_load;
  assign err_flags  = {r_err_range, r_err_unmapped};

endmodule

// File: tb/tb_mcu_bus_regfile.sv
// Bench for mcu_bus_regfile: directed vector table, multi-cycle corner sequences,
// then random bus transactions compared against an address-map level model.
module tb_mcu_bus_regfile;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] ABUS;
  tri1  [7:0] DBUS;
  logic       CSbar, ALE, Rbar, Wbar;
  logic [7:0] b0, b1, b2, b3, b4, b5, b6, operand;
  logic [4:0] hour_set;
  logic [5:0] minute_set;
  logic       time_load;
  logic [1:0] err_flags;

  logic [7:0] tb_drv;
  logic       tb_en;
  assign DBUS = tb_en ? tb_drv : 8'hzz;

  always #5 clock = ~clock;

  mcu_bus_regfile dut (
    .clock(clock), .reset(reset), .ABUS(ABUS), .DBUS(DBUS),
    .CSbar(CSbar), .ALE(ALE), .Rbar(Rbar), .Wbar(Wbar),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6),
    .operand(operand), .hour_set(hour_set), .minute_set(minute_set),
    .time_load(time_load), .err_flags(err_flags)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Address-map model: registers 0..9 and the two sticky error bits
  logic [7:0] m_reg [0:9];
  logic [1:0] m_err;

  typedef struct {
    bit          rd;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_rd;
    bit          exp_tl;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t tbl [0:21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) m_reg[i] = 8'h00;
    m_err = 2'b00;
  endtask

  task automatic model_write(input logic [15:0] a, input logic [7:0] d, output bit tl);
    tl = 1'b0;
    if (a < 16'd8) m_reg[int'(a)] = d;
    else if (a == 16'd8) begin
      if (d <= 8'd23) begin m_reg[8] = d; tl = 1'b1; end
      else m_err[1] = 1'b1;
    end else if (a == 16'd9) begin
      if (d <= 8'd59) begin m_reg[9] = d; tl = 1'b1; end
      else m_err[1] = 1'b1;
    end else if (a == 16'd10) m_err = m_err & ~d[1:0];
    else m_err[0] = 1'b1;
  endtask

  task automatic model_read(input logic [15:0] a, output logic [7:0] e);
    if (a <= 16'd9) e = m_reg[int'(a)];
    else if (a == 16'd10) e = {6'b0, m_err};
    else begin e = 8'h00; m_err[0] = 1'b1; end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".b0"}, 32'(b0), 32'(m_reg[0]));
    chk({tag, ".b1"}, 32'(b1), 32'(m_reg[1]));
    chk({tag, ".b2"}, 32'(b2), 32'(m_reg[2]));
    chk({tag, ".b3"}, 32'(b3), 32'(m_reg[3]));
    chk({tag, ".b4"}, 32'(b4), 32'(m_reg[4]));
    chk({tag, ".b5"}, 32'(b5), 32'(m_reg[5]));
    chk({tag, ".b6"}, 32'(b6), 32'(m_reg[6]));
    chk({tag, ".operand"}, 32'(operand), 32'(m_reg[7]));
    chk({tag, ".hour"}, 32'(hour_set), 32'(m_reg[8]));
    chk({tag, ".minute"}, 32'(minute_set), 32'(m_reg[9]));
    chk({tag, ".err"}, 32'(err_flags), 32'(m_err));
  endtask

  task automatic bus_idle();
    CSbar = 1'b1; ALE = 1'b0; Rbar = 1'b1; Wbar = 1'b1; tb_en = 1'b0;
    ABUS = 8'h00; tb_drv = 8'h00;
  endtask

  task automatic addr_phase(input logic [15:0] a);
    CSbar = 1'b0; ALE = 1'b1; ABUS = a[15:8]; tb_drv = a[7:0]; tb_en = 1'b1;
    @(negedge clock);
  endtask

  // tl_a: time_load in the cycle after commit; tl_b: the cycle after that
  task automatic write_tx(input logic [15:0] a, input logic [7:0] d,
                          output logic tl_a, output logic tl_b);
    addr_phase(a);
    ALE = 1'b0; Wbar = 1'b0; tb_drv = d;
    @(negedge clock);
    tl_a = time_load;
    Wbar = 1'b1; CSbar = 1'b1; tb_en = 1'b0;
    @(negedge clock);
    tl_b = time_load;
  endtask

  // d2/d3: DBUS in 2nd/3rd cycle of Rbar low; dz: cycle after Rbar rises
  task automatic read_tx(input logic [15:0] a, output logic [7:0] d2,
                         output logic [7:0] d3, output logic [7:0] dz);
    addr_phase(a);
    ALE = 1'b0; tb_en = 1'b0; Rbar = 1'b0;
    @(negedge clock);
    d2 = DBUS;
    @(negedge clock);
    d3 = DBUS;
    Rbar = 1'b1;
    @(negedge clock);
    dz = DBUS;
    CSbar = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic       tl_a, tl_b;
    bit         etl;
    logic [7:0] d2, d3, dz, e;
    logic [15:0] a;
    logic [7:0]  d;

    tbl[0]  = '{1'b0, 16'd0,      8'd13,  8'd0,  1'b0, 2'b00};
    tbl[1]  = '{1'b0, 16'd1,      8'd89,  8'd0,  1'b0, 2'b00};
    tbl[2]  = '{1'b0, 16'd2,      8'd73,  8'd0,  1'b0, 2'b00};
    tbl[3]  = '{1'b0, 16'd3,      8'd59,  8'd0,  1'b0, 2'b00};
    tbl[4]  = '{1'b0, 16'd4,      8'd23,  8'd0,  1'b0, 2'b00};
    tbl[5]  = '{1'b0, 16'd5,      8'd67,  8'd0,  1'b0, 2'b00};
    tbl[6]  = '{1'b0, 16'd6,      8'd1,   8'd0,  1'b0, 2'b00};
    tbl[7]  = '{1'b0, 16'd7,      8'hED,  8'd0,  1'b0, 2'b00};
    tbl[8]  = '{1'b0, 16'd8,      8'd23,  8'd0,  1'b1, 2'b00};
    tbl[9]  = '{1'b0, 16'd9,      8'd33,  8'd0,  1'b1, 2'b00};
    tbl[10] = '{1'b0, 16'd8,      8'd24,  8'd0,  1'b0, 2'b10};
    tbl[11] = '{1'b0, 16'd9,      8'd60,  8'd0,  1'b0, 2'b10};
    tbl[12] = '{1'b1, 16'd8,      8'd0,   8'd23, 1'b0, 2'b10};
    tbl[13] = '{1'b1, 16'd9,      8'd0,   8'd33, 1'b0, 2'b10};
    tbl[14] = '{1'b0, 16'h0100,   8'h55,  8'd0,  1'b0, 2'b11};
    tbl[15] = '{1'b1, 16'd10,     8'd0,   8'h03, 1'b0, 2'b11};
    tbl[16] = '{1'b0, 16'd10,     8'h03,  8'd0,  1'b0, 2'b00};
    tbl[17] = '{1'b1, 16'd1,      8'd0,   8'd89, 1'b0, 2'b00};
    tbl[18] = '{1'b1, 16'h0100,   8'd0,   8'h00, 1'b0, 2'b01};
    tbl[19] = '{1'b1, 16'd10,     8'd0,   8'h01, 1'b0, 2'b01};
    tbl[20] = '{1'b0, 16'd10,     8'h01,  8'd0,  1'b0, 2'b00};
    tbl[21] = '{1'b1, 16'd7,      8'd0,   8'hED, 1'b0, 2'b00};

    bus_idle();
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check_all("reset");
    chk("reset.time_load", 32'(time_load), 32'd0);
    chk("reset.dbus_hiz", 32'(DBUS), 32'hFF);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 22; i++) begin
      if (tbl[i].rd) begin
        model_read(tbl[i].addr, e);
        read_tx(tbl[i].addr, d2, d3, dz);
        chk($sformatf("tbl%0d.rd2", i), 32'(d2), 32'(tbl[i].exp_rd));
        chk($sformatf("tbl%0d.rd3", i), 32'(d3), 32'(tbl[i].exp_rd));
        chk($sformatf("tbl%0d.hiz", i), 32'(dz), 32'hFF);
      end else begin
        model_write(tbl[i].addr, tbl[i].data, etl);
        write_tx(tbl[i].addr, tbl[i].data, tl_a, tl_b);
        chk($sformatf("tbl%0d.tl", i), 32'(tl_a), 32'(tbl[i].exp_tl));
        chk($sformatf("tbl%0d.tl_end", i), 32'(tl_b), 32'd0);
      end
      chk($sformatf("tbl%0d.err", i), 32'(err_flags), 32'(tbl[i].exp_err));
      check_all($sformatf("tbl%0d", i));
    end
    chk("seq.b0", 32'(b0), 32'd13);
    chk("seq.b3", 32'(b3), 32'd59);
    chk("seq.b6", 32'(b6), 32'd1);
    chk("seq.operand", 32'(operand), 32'hED);
    chk("seq.hour", 32'(hour_set), 32'd23);
    chk("seq.minute", 32'(minute_set), 32'd33);

    // Wbar held low over three data cycles: only the first value lands
    addr_phase(16'd2);
    ALE = 1'b0; Wbar = 1'b0; tb_drv = 8'h11;
    @(negedge clock);
    tb_drv = 8'h22;
    @(negedge clock);
    tb_drv = 8'h33;
    @(negedge clock);
    Wbar = 1'b1; CSbar = 1'b1; tb_en = 1'b0;
    @(negedge clock);
    m_reg[2] = 8'h11;
    chk("hold.b2", 32'(b2), 32'h11);
    check_all("hold");

    // ALE re-asserted in ADDR, then a second Wbar pulse in the same select
    addr_phase(16'd3);
    addr_phase(16'd4);
    ALE = 1'b0; Wbar = 1'b0; tb_drv = 8'h5A;
    @(negedge clock);
    Wbar = 1'b1;
    @(negedge clock);
    Wbar = 1'b0; tb_drv = 8'hA5;
    @(negedge clock);
    Wbar = 1'b1; CSbar = 1'b1; tb_en = 1'b0;
    @(negedge clock);
    m_reg[4] = 8'h5A;
    chk("realе.b4", 32'(b4), 32'h5A);
    chk("reale.b3", 32'(b3), 32'd59);
    check_all("reale");

    // Reset asserted while a read is driving the bus
    addr_phase(16'd1);
    ALE = 1'b0; tb_en = 1'b0; Rbar = 1'b0;
    @(negedge clock);
    chk("rstrd.drive", 32'(DBUS), 32'd89);
    reset = 1'b0;
    @(negedge clock);
    model_reset();
    chk("rstrd.hiz", 32'(DBUS), 32'hFF);
    check_all("rstrd");
    reset = 1'b1;
    bus_idle();
    @(negedge clock);
    model_write(16'd6, 8'h77, etl);
    write_tx(16'd6, 8'h77, tl_a, tl_b);
    model_read(16'd6, e);
    read_tx(16'd6, d2, d3, dz);
    chk("post.rd", 32'(d2), 32'h77);
    chk("post.hiz", 32'(dz), 32'hFF);
    check_all("post");

    for (int i = 0; i < 200; i++) begin
      a = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(11, 65535))
                                      : 16'($urandom_range(0, 10));
      d = 8'($urandom);
      if (a == 16'd8 || a == 16'd9) d = 8'($urandom_range(0, 70));
      if ($urandom_range(0, 2) == 0) begin
        model_read(a, e);
        read_tx(a, d2, d3, dz);
        chk($sformatf("rnd%0d.rd2 a=%0h", i, a), 32'(d2), 32'(e));
        chk($sformatf("rnd%0d.rd3 a=%0h", i, a), 32'(d3), 32'(e));
        chk($sformatf("rnd%0d.hiz", i), 32'(dz), 32'hFF);
      end else begin
        model_write(a, d, etl);
        write_tx(a, d, tl_a, tl_b);
        chk($sformatf("rnd%0d.tl a=%0h d=%0h", i, a, d), 32'(tl_a), 32'(etl));
        chk($sformatf("rnd%0d.tl_end", i), 32'(tl_b), 32'd0);
      end
      check_all($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
